// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NCH stream demultiplexer with valid/ready flow control.
// Routing comes from s_sel (MODE=0) or an internal round-robin pointer (MODE=1).
module demux_stream_1ton #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int MODE  = 0,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic [SELW-1:0]      s_sel,
  output logic [NCH-1:0]       m_valid,
  input  logic [NCH-1:0]       m_ready,
  output logic [NCH*WIDTH-1:0] m_data,
  output logic [SELW-1:0]      rr_ptr,
  output logic                 sel_err,
  output logic [CNTW-1:0]      drop_cnt
);

  localparam logic [SELW:0]   NCH_L  = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_L = SELW'(NCH-1);

  // The hold register is kept directly in output form: one-hot valid plus
  // a data vector that is zero outside the destination slice.
  logic [NCH-1:0]       m_valid_r;
  logic [NCH-1:0]       m_valid_nxt_s;
  logic [NCH-1:0]       dest_oh_s;
  logic [NCH*WIDTH-1:0] m_data_r;
  logic [NCH*WIDTH-1:0] m_data_nxt_s;
  logic [SELW-1:0]      rr_ptr_r;
  logic [SELW-1:0]      rr_ptr_nxt_s;
  logic [SELW-1:0]      dest_s;
  logic                 sel_err_r;
  logic                 sel_err_nxt_s;
  logic [CNTW-1:0]      drop_cnt_r;
  logic [CNTW-1:0]      drop_cnt_nxt_s;
  logic                 drain_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 in_range_s;

  // Handshake and destination decode
  always_comb begin
    drain_s  = |(m_valid_r & m_ready);
    ready_s  = ~(|m_valid_r) | drain_s;
    accept_s = s_valid & ready_s;
    if (MODE == 1) begin
      dest_s = rr_ptr_r;
    end else begin
      dest_s = s_sel;
    end
    in_range_s = ({1'b0, dest_s} < NCH_L);
    for (int k = 0; k < NCH; k++) begin
      dest_oh_s[k] = (dest_s == SELW'(k));
    end
  end

  // Next-state for hold register, round-robin pointer and drop accounting
  always_comb begin
    m_valid_nxt_s = m_valid_r;
    m_data_nxt_s  = m_data_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    // Load wins over drain: a drain and a new beat in the same edge leave no bubble.
    if (accept_s && in_range_s) begin
      m_valid_nxt_s = dest_oh_s;
      for (int k = 0; k < NCH; k++) begin
        m_data_nxt_s[k*WIDTH +: WIDTH] = dest_oh_s[k] ? s_data : {WIDTH{1'b0}};
      end
    end else if (drain_s) begin
      m_valid_nxt_s = {NCH{1'b0}};
      m_data_nxt_s  = {(NCH*WIDTH){1'b0}};
    end else begin
      m_valid_nxt_s = m_valid_r;
      m_data_nxt_s  = m_data_r;
    end
    if ((MODE == 1) && accept_s) begin
      if (rr_ptr_r == LAST_L) begin
        rr_ptr_nxt_s = {SELW{1'b0}};
      end else begin
        rr_ptr_nxt_s = rr_ptr_r + SELW'(1'b1);
      end
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
    sel_err_nxt_s = accept_s & ~in_range_s;
    if (sel_err_nxt_s && (drop_cnt_r != {CNTW{1'b1}})) begin
      drop_cnt_nxt_s = drop_cnt_r + CNTW'(1'b1);
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r  <= {NCH{1'b0}};
      m_data_r   <= {(NCH*WIDTH){1'b0}};
      rr_ptr_r   <= {SELW{1'b0}};
      sel_err_r  <= 1'b0;
      drop_cnt_r <= {CNTW{1'b0}};
    end else begin
      m_valid_r  <= m_valid_nxt_s;
      m_data_r   <= m_data_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      sel_err_r  <= sel_err_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  assign s_ready  = ready_s;
  assign m_valid  = m_valid_r;
  assign m_data   = m_data_r;
  assign rr_ptr   = rr_ptr_r;
  assign sel_err  = sel_err_r;
  assign drop_cnt = drop_cnt_r;

endmodule
